// File: rtl/cpu_trace_monitor.sv
// ---------------------------------------------------------------------------
// cpu_trace_monitor
//
// Retire-event tracer that sits beside the CPU. It watches the writeback and
// data-memory strobes, merges everything that happens in one cycle into a
// single time-stamped record, and pushes that record into an on-chip FIFO
// that a host/debug reader drains through a valid/ready port. It also keeps
// live cycle/instruction counters, a watchdog and halt detection.
//
// Optional feature (compile-time macro):
//   TRACE_ADDR_FILTER_EN  - when defined, memory events are recorded only for
//                           FILT_LO <= mem_addr <= FILT_HI. When undefined,
//                           every memory event is recorded.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   reg_wen        register file write this cycle
//   reg_dest       register index written
//   reg_data       value written to the register
//   mem_ren        data memory read this cycle
//   mem_wen        data memory write this cycle
//   mem_addr       data memory address
//   mem_wdata      data written to memory
//   mem_rdata      data read from memory
//   halt           halt has reached memory/writeback stage
//   trace_valid    FIFO holds at least one record
//   trace_ready    reader accepts the head record
//   trace_data     head record (0 while the FIFO is empty)
//   cycle_count    cycles spent in RUN
//   inst_count     retired instructions
//   halted         sticky, halt seen
//   timed_out      sticky, watchdog fired
//   overflow       sticky, at least one record dropped
//   drop_count     dropped records, saturating at 16'hFFFF
//   state_dbg      current monitor state (0=RUN, 1=HALTED, 2=TIMEOUT)
//
// Handshake: a record transfers on every rising clk edge where
// trace_valid && trace_ready. trace_valid never depends on trace_ready, and
// trace_data stays stable while trace_valid is high and the record has not
// been accepted.
//
// Record layout, MSB to LSB:
//   flags[4:0] = {timeout, halt, mem_w, mem_r, reg_w}
//   stamp[CYC_W-1:0], reg_dest, reg_data, mem_addr, mem_data
// Any field whose flag is clear is zero.
// ---------------------------------------------------------------------------
module cpu_trace_monitor #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int REG_IDX_W = 4,
    parameter int DEPTH     = 32,
    parameter int CYC_W     = 32,
    parameter int TIMEOUT   = 100000,
    parameter int FILT_LO   = 0,
    parameter int FILT_HI   = 2**ADDR_W - 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   reg_wen,
    input  logic [REG_IDX_W-1:0]                                   reg_dest,
    input  logic [DATA_W-1:0]                                      reg_data,
    input  logic                                                   mem_ren,
    input  logic                                                   mem_wen,
    input  logic [ADDR_W-1:0]                                      mem_addr,
    input  logic [DATA_W-1:0]                                      mem_wdata,
    input  logic [DATA_W-1:0]                                      mem_rdata,
    input  logic                                                   halt,
    output logic                                                   trace_valid,
    input  logic                                                   trace_ready,
    output logic [5+CYC_W+REG_IDX_W+DATA_W+ADDR_W+DATA_W-1:0]      trace_data,
    output logic [CYC_W-1:0]                                       cycle_count,
    output logic [CYC_W-1:0]                                       inst_count,
    output logic                                                   halted,
    output logic                                                   timed_out,
    output logic                                                   overflow,
    output logic [15:0]                                            drop_count,
    output logic [1:0]                                             state_dbg
);

    localparam int REC_W = 5 + CYC_W + REG_IDX_W + DATA_W + ADDR_W + DATA_W;
    localparam int PTR_W = $clog2(DEPTH);

    // Watchdog fires in the RUN cycle whose stamp is TIMEOUT-1.
    localparam logic [CYC_W-1:0] WD_LAST = CYC_W'(TIMEOUT - 1);

    // Elaboration-time sanity checks on the configuration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cpu_trace_monitor: DEPTH must be a power of two >= 2");
    end
    if (FILT_LO > FILT_HI) begin : g_bad_filter
        $error("cpu_trace_monitor: FILT_LO must not exceed FILT_HI");
    end

    // -----------------------------------------------------------------------
    // Monitor state machine
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic run;
    logic wd_fire;

    assign run       = (state == ST_RUN);
    // Halt in the same cycle wins over the watchdog.
    assign wd_fire   = run && (cycle_count == WD_LAST) && !halt;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_HALTED;
                end else if (wd_fire) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            // HALTED and TIMEOUT are left only through reset.
            ST_HALTED:  state_nxt = ST_HALTED;
            ST_TIMEOUT: state_nxt = ST_TIMEOUT;
            default:    state_nxt = ST_RUN;
        endcase
    end

    // -----------------------------------------------------------------------
    // Address filter
    // -----------------------------------------------------------------------
    logic addr_in_range;

`ifdef TRACE_ADDR_FILTER_EN
    localparam logic [ADDR_W-1:0] FILT_LO_A = ADDR_W'(FILT_LO);
    localparam logic [ADDR_W-1:0] FILT_HI_A = ADDR_W'(FILT_HI);
    assign addr_in_range = (mem_addr >= FILT_LO_A) && (mem_addr <= FILT_HI_A);
`else
    assign addr_in_range = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Record assembly
    // -----------------------------------------------------------------------
    logic              f_reg;
    logic              f_mr;
    logic              f_mw;
    logic              f_halt;
    logic              f_to;
    logic              capture;
    logic [REC_W-1:0]  rec;
    logic [REG_IDX_W-1:0] rec_dest;
    logic [DATA_W-1:0] rec_rdata;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_mdata;

    always_comb begin
        f_reg     = reg_wen;
        f_mr      = mem_ren && addr_in_range;
        f_mw      = mem_wen && addr_in_range;
        f_halt    = halt;
        f_to      = wd_fire;
        capture   = run && (f_reg || f_mr || f_mw || f_halt || f_to);

        rec_dest  = f_reg ? reg_dest : '0;
        rec_rdata = f_reg ? reg_data : '0;
        rec_addr  = (f_mr || f_mw) ? mem_addr : '0;
        // A write takes precedence over a read for the data field.
        if (f_mw) begin
            rec_mdata = mem_wdata;
        end else if (f_mr) begin
            rec_mdata = mem_rdata;
        end else begin
            rec_mdata = '0;
        end

        rec = {f_to, f_halt, f_mw, f_mr, f_reg,
               cycle_count, rec_dest, rec_rdata, rec_addr, rec_mdata};
    end

    // -----------------------------------------------------------------------
    // Counters and sticky flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count <= '0;
            inst_count  <= '0;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            if (run) begin
                cycle_count <= cycle_count + 1'b1;
                // A lone memory read is not a retired instruction.
                if (halt || reg_wen || mem_wen) begin
                    inst_count <= inst_count + 1'b1;
                end
            end
            // Set even when the corresponding record is dropped.
            if (run && halt) begin
                halted <= 1'b1;
            end
            if (wd_fire) begin
                timed_out <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Trace FIFO: pointers carry one extra wrap bit so full and empty are
    // distinguishable when the index bits match.
    // -----------------------------------------------------------------------
    logic [REC_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign trace_valid = !fifo_empty;
    assign trace_data  = fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];

    assign pop     = trace_valid && trace_ready;
    // A full FIFO still takes a record when the head leaves in the same cycle.
    assign push_ok = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    // Storage needs no reset: reads are gated by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= rec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_trace_monitor
//
// Directed bench for cpu_trace_monitor with a small FIFO (DEPTH=4) and a
// short watchdog (TIMEOUT=20). Filter window is 0x100..0x1FF; its effect is
// only expected when TRACE_ADDR_FILTER_EN is defined.
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// at that same point, after the edge's updates have settled.
// ---------------------------------------------------------------------------
module tb_cpu_trace_monitor;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int REG_IDX_W = 4;
  localparam int DEPTH     = 4;
  localparam int CYC_W     = 32;
  localparam int TIMEOUT   = 20;
  localparam int REC_W     = 5 + CYC_W + REG_IDX_W + DATA_W + ADDR_W + DATA_W;

  // clock / reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic                 reg_wen;
  logic [REG_IDX_W-1:0] reg_dest;
  logic [DATA_W-1:0]    reg_data;
  logic                 mem_ren;
  logic                 mem_wen;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 halt;
  logic                 trace_valid;
  logic                 trace_ready;
  logic [REC_W-1:0]     trace_data;
  logic [CYC_W-1:0]     cycle_count;
  logic [CYC_W-1:0]     inst_count;
  logic                 halted;
  logic                 timed_out;
  logic                 overflow;
  logic [15:0]          drop_count;
  logic [1:0]           state_dbg;

  cpu_trace_monitor #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_IDX_W(REG_IDX_W), .DEPTH(DEPTH),
    .CYC_W(CYC_W), .TIMEOUT(TIMEOUT), .FILT_LO(32'h100), .FILT_HI(32'h1FF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_wen(reg_wen), .reg_dest(reg_dest), .reg_data(reg_data),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .cycle_count(cycle_count), .inst_count(inst_count), .halted(halted),
    .timed_out(timed_out), .overflow(overflow), .drop_count(drop_count),
    .state_dbg(state_dbg)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] make_rec(input logic [4:0] f, input logic [31:0] st,
                                                input logic [3:0] d, input logic [15:0] rdat,
                                                input logic [15:0] a, input logic [15:0] md);
    return {f, st, d, rdat, a, md};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_wen   = 1'b0;
    reg_dest  = '0;
    reg_data  = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rdata = '0;
    halt      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    trace_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic reg_write(input logic [3:0] d, input logic [15:0] v);
    idle_inputs();
    reg_wen  = 1'b1;
    reg_dest = d;
    reg_data = v;
  endtask

  initial begin
    idle_inputs();
    trace_ready = 1'b0;
    rst_n = 1'b0;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_valid", trace_valid, 0);
    check("rst_data", trace_data, 0);
    check("rst_cycle", cycle_count, 0);
    check("rst_inst", inst_count, 0);
    check("rst_halted", halted, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drops", drop_count, 0);
    check("rst_state", state_dbg, 2'd0);

    // ---------------- basic capture ----------------
    // cycle 0: r3 <= BEEF
    reg_write(4'd3, 16'hBEEF);
    step();
    idle_inputs();
    check("first_valid", trace_valid, 1);
    check("first_rec", trace_data, make_rec(5'b00001, 0, 4'd3, 16'hBEEF, 0, 0));
    check("first_inst", inst_count, 1);
    check("first_cycle", cycle_count, 1);

    // cycle 1: r5 <= 0x0011 and store 0x1234 to 0x0040, merged
    reg_write(4'd5, 16'h0011);
    mem_wen   = 1'b1;
    mem_addr  = 16'h0040;
    mem_wdata = 16'h1234;
    step();
    idle_inputs();
    check("merge_inst", inst_count, 2);
    check("merge_head_unchanged", trace_data, make_rec(5'b00001, 0, 4'd3, 16'hBEEF, 0, 0));

    // cycle 2: pop first record
    trace_ready = 1'b1;
    step();
    check("merge_rec", trace_data, make_rec(5'b00101, 1, 4'd5, 16'h0011, 16'h0040, 16'h1234));
    // cycle 3: pop second record
    step();
    check("drained_valid", trace_valid, 0);
    check("drained_data", trace_data, 0);
    trace_ready = 1'b0;

    // cycle 4: load from 0x0080 (outside filter window)
    mem_ren   = 1'b1;
    mem_addr  = 16'h0080;
    mem_rdata = 16'h5555;
    step();
    idle_inputs();
`ifdef TRACE_ADDR_FILTER_EN
    check("filt_out_valid", trace_valid, 0);
`else
    check("load_rec", trace_data, make_rec(5'b00010, 4, 0, 0, 16'h0080, 16'h5555));
`endif
    check("load_inst", inst_count, 2);

    // cycle 5: load from 0x0150 while popping any pending record
    trace_ready = 1'b1;
    mem_ren   = 1'b1;
    mem_addr  = 16'h0150;
    mem_rdata = 16'hAAAA;
    step();
    idle_inputs();
    check("load2_rec", trace_data, make_rec(5'b00010, 5, 0, 0, 16'h0150, 16'hAAAA));
    // cycle 6: drain
    step();
    trace_ready = 1'b0;
    check("load2_drained", trace_valid, 0);
    check("pre_halt_cycle", cycle_count, 7);

    // ---------------- halt ----------------
    // cycle 7: halt
    halt = 1'b1;
    step();
    idle_inputs();
    check("halt_rec", trace_data, make_rec(5'b01000, 7, 0, 0, 0, 0));
    check("halt_flag", halted, 1);
    check("halt_state", state_dbg, 2'd1);
    check("halt_cycle", cycle_count, 8);
    check("halt_inst", inst_count, 3);
    reg_write(4'd1, 16'h0001);
    step();
    check("halted_cycle_frozen", cycle_count, 8);
    check("halted_inst_frozen", inst_count, 3);
    check("halted_head_kept", trace_data, make_rec(5'b01000, 7, 0, 0, 0, 0));
    trace_ready = 1'b1;
    step();
    check("halted_drain", trace_valid, 0);
    step();
    check("halted_no_capture", trace_valid, 0);
    check("halted_timed_out", timed_out, 0);
    idle_inputs();
    trace_ready = 1'b0;

    // ---------------- overflow ----------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      reg_write(4'(i), 16'(16'h0100 + i));
      step();
    end
    idle_inputs();
    check("ovf_valid", trace_valid, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 2);
    check("ovf_inst", inst_count, 6);
    // cycle 6: full FIFO, push accepted because the head leaves
    trace_ready = 1'b1;
    reg_write(4'd9, 16'h0109);
    step();
    idle_inputs();
    check("ovf_pop_push_drops", drop_count, 2);
    for (int i = 1; i < 4; i++) begin
      check("ovf_drain_rec", trace_data, make_rec(5'b00001, 32'(i), 4'(i), 16'(16'h0100 + i), 0, 0));
      step();
    end
    check("ovf_last_rec", trace_data, make_rec(5'b00001, 6, 4'd9, 16'h0109, 0, 0));
    step();
    check("ovf_empty", trace_valid, 0);
    trace_ready = 1'b0;

    // reset mid-operation discards buffered records
    reg_write(4'd2, 16'h0002);
    step();
    step();
    idle_inputs();
    check("mid_valid_before", trace_valid, 1);
    do_reset();
    check("mid_valid_after", trace_valid, 0);
    check("mid_ovf_after", overflow, 0);
    check("mid_drops_after", drop_count, 0);

    // ---------------- watchdog ----------------
    for (int i = 0; i < 19; i++) step();
    check("wd_pre_cycle", cycle_count, 19);
    check("wd_pre_flag", timed_out, 0);
    step();
    check("wd_rec", trace_data, make_rec(5'b10000, 19, 0, 0, 0, 0));
    check("wd_flag", timed_out, 1);
    check("wd_halted", halted, 0);
    check("wd_state", state_dbg, 2'd2);
    for (int i = 0; i < 3; i++) step();
    check("wd_cycle_frozen", cycle_count, 20);

    // halt on the watchdog cycle wins
    do_reset();
    for (int i = 0; i < 19; i++) step();
    halt = 1'b1;
    step();
    idle_inputs();
    check("wdh_rec", trace_data, make_rec(5'b01000, 19, 0, 0, 0, 0));
    check("wdh_halted", halted, 1);
    check("wdh_timed_out", timed_out, 0);
    check("wdh_state", state_dbg, 2'd1);
    check("wdh_cycle", cycle_count, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
